// File: rtl/disk_sector_server_if.sv
// Controller and block-storage signal bundle for disk_sector_server.
// master: the sector server; slave: controller command/FIFO side plus the storage engine.
interface disk_sector_server_if;
    logic [31:0] dsr;
    logic [31:0] dcr;
    logic [7:0]  dd0in;
    logic        dd0inclk;
    logic [7:0]  dd0out;
    logic        dd0outclk;
    logic        blk_req;
    logic        blk_we;
    logic [31:0] blk_lba;
    logic        blk_ack;
    logic [7:0]  blk_rdata;
    logic        blk_rvalid;
    logic [7:0]  blk_wdata;
    logic        blk_wvalid;
    logic        blk_wready;
    logic        blk_done;

    modport master (
        input  dsr, dd0out, blk_ack, blk_rdata, blk_rvalid, blk_wready, blk_done,
        output dcr, dd0in, dd0inclk, dd0outclk, blk_req, blk_we, blk_lba, blk_wdata, blk_wvalid
    );

    modport slave (
        output dsr, dd0out, blk_ack, blk_rdata, blk_rvalid, blk_wready, blk_done,
        input  dcr, dd0in, dd0inclk, dd0outclk, blk_req, blk_we, blk_lba, blk_wdata, blk_wvalid
    );
endinterface

// File: rtl/disk_sector_server.sv
// Sector server: maps dsr drive/side/track/sector to a storage LBA and moves 512 bytes between storage and controller.
// Latency: command to blk_req 2 cycles; read byte to dd0inclk 1 cycle; write 1 byte per >=2 cycles.
// Backpressure: blk_req held until blk_ack, blk_wvalid held until blk_wready; DISK_SERVER_TIMEOUT_EN adds a storage watchdog.
module disk_sector_server #(
    parameter int unsigned SECTORS_PER_TRACK = 10,
    parameter int unsigned TRACKS            = 80,
    parameter logic [31:0] DRIVE0_BASE       = 32'h0000_0000,
    parameter logic [31:0] DRIVE1_BASE       = 32'h0000_0800,
    parameter logic [31:0] TIMEOUT_CYCLES    = 32'd50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    disk_sector_server_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_REQ, S_RD_STREAM, S_WR_FETCH,
        S_WR_HOLD, S_WR_WAIT, S_DONE, S_RELEASE
    } state_t;

    localparam logic [9:0] SECTOR_BYTES = 10'd512;

    state_t      state_q, state_d;
    logic [4:0]  sector_q, sector_d;
    logic [6:0]  track_q, track_d;
    logic        side_q, side_d;
    logic        drive_q, drive_d;
    logic        wr_q, wr_d;
    logic        rnf_q, rnf_d;
    logic [31:0] lba_q, lba_d;
    logic [7:0]  dd0in_q, dd0in_d;
    logic        dd0inclk_q, dd0inclk_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        done_pend_q, done_pend_d;

    logic        cmd_any;
    logic        ack_ok;
    logic        bad_req;
    logic [31:0] lba_off;
    logic        tmo_hit;
    logic        unused_dsr;

    assign cmd_any    = bus.dsr[17] | bus.dsr[18] | bus.dsr[20] | bus.dsr[21];
    assign ack_ok     = bus.dsr[16] & ~cmd_any;
    assign bad_req    = (sector_q == 5'd0) || (32'(sector_q) > SECTORS_PER_TRACK) ||
                        (32'(track_q) >= TRACKS);
    assign lba_off    = (32'(track_q) * 32'd2 + 32'(side_q)) * SECTORS_PER_TRACK +
                        32'(sector_q) - 32'd1;
    assign unused_dsr = ^{bus.dsr[31:22], bus.dsr[19], bus.dsr[15:13]};

`ifdef DISK_SERVER_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        tmo_active;

    assign tmo_active = (state_q == S_REQ) || (state_q == S_RD_STREAM) ||
                        (state_q == S_WR_FETCH) || (state_q == S_WR_HOLD) ||
                        (state_q == S_WR_WAIT);
    assign tmo_hit    = tmo_active && (tmo_q >= TIMEOUT_CYCLES - 32'd1);

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == S_CHECK) begin
            tmo_d = '0;
        end else if (tmo_active) begin
            tmo_d = tmo_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sector_q    <= '0;
            track_q     <= '0;
            side_q      <= 1'b0;
            drive_q     <= 1'b0;
            wr_q        <= 1'b0;
            rnf_q       <= 1'b0;
            lba_q       <= '0;
            dd0in_q     <= '0;
            dd0inclk_q  <= 1'b0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            done_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sector_q    <= sector_d;
            track_q     <= track_d;
            side_q      <= side_d;
            drive_q     <= drive_d;
            wr_q        <= wr_d;
            rnf_q       <= rnf_d;
            lba_q       <= lba_d;
            dd0in_q     <= dd0in_d;
            dd0inclk_q  <= dd0inclk_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            done_pend_q <= done_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sector_d    = sector_q;
        track_d     = track_q;
        side_d      = side_q;
        drive_d     = drive_q;
        wr_d        = wr_q;
        rnf_d       = rnf_q;
        lba_d       = lba_q;
        dd0in_d     = dd0in_q;
        dd0inclk_d  = 1'b0;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        done_pend_d = done_pend_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_any) begin
                    sector_d    = bus.dsr[4:0];
                    track_d     = bus.dsr[11:5];
                    side_d      = bus.dsr[12];
                    drive_d     = ~bus.dsr[17] & (bus.dsr[18] | (~bus.dsr[20] & bus.dsr[21]));
                    wr_d        = ~bus.dsr[17] & ~bus.dsr[18];
                    rnf_d       = 1'b0;
                    cnt_d       = '0;
                    done_pend_d = 1'b0;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bad_req) begin
                    rnf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    lba_d   = (drive_q ? DRIVE1_BASE : DRIVE0_BASE) + lba_off;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.blk_ack) begin
                    state_d = wr_q ? S_WR_FETCH : S_RD_STREAM;
                end
            end
            S_RD_STREAM: begin
                if (bus.blk_rvalid && (cnt_q != SECTOR_BYTES)) begin
                    dd0in_d    = bus.blk_rdata;
                    dd0inclk_d = 1'b1;
                    cnt_d      = cnt_q + 10'd1;
                end
                if (bus.blk_done || done_pend_q) begin
                    if (cnt_q == SECTOR_BYTES) begin
                        state_d = S_DONE;
                    end else if (cnt_d == SECTOR_BYTES) begin
                        // final byte arrived with done: let its strobe lead dcr[4]
                        done_pend_d = 1'b1;
                    end else begin
                        rnf_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_WR_FETCH: begin
                wdata_d = bus.dd0out;
                state_d = S_WR_HOLD;
            end
            S_WR_HOLD: begin
                if (bus.blk_wready) begin
                    cnt_d   = cnt_q + 10'd1;
                    state_d = (cnt_d == SECTOR_BYTES) ? S_WR_WAIT : S_WR_FETCH;
                end
            end
            S_WR_WAIT: begin
                if (bus.blk_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ack_ok) begin
                    rnf_d   = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!bus.dsr[16]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_hit) begin
            rnf_d   = 1'b1;
            state_d = S_DONE;
        end
    end

    always_comb begin
        bus.dcr        = {27'd0, (state_q == S_DONE), rnf_q, 3'd0};
        bus.blk_req    = (state_q == S_REQ);
        bus.blk_we     = (state_q == S_REQ) && wr_q;
        bus.blk_lba    = lba_q;
        bus.blk_wvalid = (state_q == S_WR_HOLD);
        bus.blk_wdata  = wdata_q;
        // pop only from FETCH, which is always followed by HOLD, so pops never abut
        bus.dd0outclk  = (state_q == S_WR_FETCH);
        bus.dd0in      = dd0in_q;
        bus.dd0inclk   = dd0inclk_q;
    end
endmodule

// File: tb/tb_disk_sector_server.sv
// Directed bench for disk_sector_server: scoreboard queues for read bytes toward the controller and write bytes toward storage.
module tb_disk_sector_server;
    logic clk = 1'b0;
    logic reset;

    disk_sector_server_if bus ();

    disk_sector_server dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] rd_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] fifo[512];

    localparam logic [31:0] ACK  = 32'h0001_0000;
    localparam logic [31:0] RD0  = 32'h0002_0000;
    localparam logic [31:0] RD1  = 32'h0004_0000;
    localparam logic [31:0] WR0  = 32'h0010_0000;
    localparam logic [31:0] SIDE = 32'h0000_1000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // read bytes must arrive in order, one strobe per pushed byte
    always @(negedge clk) begin
        if (!reset && bus.dd0inclk === 1'b1) begin
            check("rd_strobe_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) check("rd_byte", 32'(bus.dd0in), 32'(rd_q.pop_front()));
        end
    end

    task automatic release_cmd(input logic [31:0] cmd, input logic [31:0] dcr_exp);
        bus.dsr = cmd | ACK;
        tick();
        check("done_hold_while_cmd", bus.dcr, dcr_exp);
        bus.dsr = ACK;
        tick();
        check("release_dcr", bus.dcr, 32'h0);
        bus.dsr = cmd | ACK;
        tick();
        check("release_ignores_cmd", 32'(bus.blk_req), 32'd0);
        bus.dsr = 32'h0;
        tick();
        check("idle_dcr", bus.dcr, 32'h0);
    endtask

    task automatic start_cmd(input logic [31:0] cmd, input logic [31:0] lba_exp, input logic we_exp);
        bus.dsr = cmd;
        tick();
        check("req_lat_c1", 32'(bus.blk_req), 32'd0);
        tick();
        check("req_lat_c2", 32'(bus.blk_req), 32'd1);
        check("req_lba", bus.blk_lba, lba_exp);
        check("req_we", 32'(bus.blk_we), 32'(we_exp));
        tick();
        check("req_held", 32'(bus.blk_req), 32'd1);
        bus.blk_ack = 1'b1;
        tick();
        bus.blk_ack = 1'b0;
        check("req_drop_after_ack", 32'(bus.blk_req), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] cmd, input logic [31:0] lba_exp, input int nbytes,
                           input int extra, input logic [31:0] dcr_exp);
        start_cmd(cmd, lba_exp, 1'b0);
        for (int i = 0; i < nbytes + extra; i++) begin
            bus.blk_rvalid = 1'b1;
            bus.blk_rdata  = (i < nbytes) ? 8'(i) : 8'hEE;
            if (i < nbytes) rd_q.push_back(8'(i));
            tick();
        end
        bus.blk_rvalid = 1'b0;
        tick();
        check("rd_dcr_before_done", bus.dcr, 32'h0);
        bus.blk_done = 1'b1;
        tick();
        bus.blk_done = 1'b0;
        check("rd_dcr_after_done", bus.dcr, dcr_exp);
        check("rd_all_delivered", 32'(rd_q.size()), 32'd0);
        release_cmd(cmd, dcr_exp);
    endtask

    task automatic do_invalid(input logic [31:0] cmd);
        bus.dsr = cmd;
        tick();
        check("inv_req_c1", 32'(bus.blk_req), 32'd0);
        check("inv_dcr_c1", bus.dcr, 32'h0);
        tick();
        check("inv_dcr_c2", bus.dcr, 32'h18);
        check("inv_req_c2", 32'(bus.blk_req), 32'd0);
        release_cmd(cmd, 32'h18);
    endtask

    task automatic do_write();
        logic [31:0] cmd;
        int          fptr, npop, nadj, nacc, nlate;
        logic        prev_oclk, popnow;
        cmd = WR0 | (32'd2 << 5) | 32'd3;
        for (int i = 0; i < 512; i++) begin
            fifo[i] = 8'(32'hA5 + i * 5);
            wr_q.push_back(fifo[i]);
        end
        fptr = 0; npop = 0; nadj = 0; nacc = 0; nlate = 0;
        prev_oclk  = 1'b0;
        bus.dd0out = fifo[0];
        start_cmd(cmd, 32'h2A, 1'b1);
        for (int c = 0; c < 4000 && nacc < 512; c++) begin
            bus.blk_wready = (c % 5 != 4);
            if (bus.dd0outclk) begin
                npop++;
                if (prev_oclk) nadj++;
            end
            prev_oclk = bus.dd0outclk;
            if (bus.blk_wvalid && bus.blk_wready) begin
                nacc++;
                if (wr_q.size() != 0) check("wr_byte", 32'(bus.blk_wdata), 32'(wr_q.pop_front()));
            end
            popnow = bus.dd0outclk;
            tick();
            if (popnow && fptr < 511) begin
                fptr++;
                bus.dd0out = fifo[fptr];
            end
        end
        bus.blk_wready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (bus.dd0outclk || bus.blk_wvalid) nlate++;
            tick();
        end
        bus.blk_wready = 1'b0;
        check("wr_accepted", 32'(nacc), 32'd512);
        check("wr_pops", 32'(npop), 32'd512);
        check("wr_adjacent_pops", 32'(nadj), 32'd0);
        check("wr_activity_after_512", 32'(nlate), 32'd0);
        check("wr_dcr_before_done", bus.dcr, 32'h0);
        bus.blk_done = 1'b1;
        tick();
        bus.blk_done = 1'b0;
        check("wr_dcr_after_done", bus.dcr, 32'h10);
        release_cmd(cmd, 32'h10);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dcr"}, bus.dcr, 32'h0);
        check({tag, "_dd0in"}, 32'(bus.dd0in), 32'h0);
        check({tag, "_dd0inclk"}, 32'(bus.dd0inclk), 32'h0);
        check({tag, "_dd0outclk"}, 32'(bus.dd0outclk), 32'h0);
        check({tag, "_blk_req"}, 32'(bus.blk_req), 32'h0);
        check({tag, "_blk_we"}, 32'(bus.blk_we), 32'h0);
        check({tag, "_blk_lba"}, bus.blk_lba, 32'h0);
        check({tag, "_blk_wvalid"}, 32'(bus.blk_wvalid), 32'h0);
        check({tag, "_blk_wdata"}, 32'(bus.blk_wdata), 32'h0);
    endtask

    initial begin
        logic [31:0] cmd;
        reset          = 1'b1;
        bus.dsr        = 32'h0;
        bus.dd0out     = 8'h0;
        bus.blk_ack    = 1'b0;
        bus.blk_rdata  = 8'h0;
        bus.blk_rvalid = 1'b0;
        bus.blk_wready = 1'b0;
        bus.blk_done   = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        do_read(RD0 | 32'd1, 32'h0, 512, 1, 32'h10);
        do_read(RD1 | SIDE | (32'd79 << 5) | 32'd10, 32'hE3F, 3, 0, 32'h18);

        do_invalid(RD0 | 32'd0);
        do_invalid(RD1 | 32'd11);
        do_invalid(WR0 | (32'd80 << 5) | 32'd1);

        do_write();

        // read wins over a simultaneous write; then reset in mid-stream
        cmd = RD0 | WR0 | (32'd1 << 5) | 32'd2;
        start_cmd(cmd, 32'h15, 1'b0);
        for (int i = 0; i < 100; i++) begin
            bus.blk_rvalid = 1'b1;
            bus.blk_rdata  = 8'(i);
            rd_q.push_back(8'(i));
            tick();
        end
        bus.blk_rvalid = 1'b0;
        tick();
        check("mid_rd_delivered", 32'(rd_q.size()), 32'd0);
        bus.dsr = 32'h0;
        reset   = 1'b1;
        tick();
        check_all_zero("mid_reset");
        reset = 1'b0;
        tick();

        do_read(RD0 | 32'd1, 32'h0, 512, 0, 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end
endmodule
